// File: rtl/encoder_interval_ctrl.sv
// Encoder position counter and A-to-A interval timer for the belt drive.
// Intervals are published on a valid/ready port; a missing A edge for TIMEOUT ticks flags a stop.
module encoder_interval_ctrl #(
  parameter int unsigned CNT_W   = 9,
  parameter int unsigned INT_W   = 9,
  parameter int unsigned TIMEOUT = 511
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             tick,
  input  logic             clear,
  output logic [CNT_W-1:0] encoder_counter,
  output logic [INT_W-1:0] interval_time,
  output logic             dir,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             stopped,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

  localparam logic [INT_W-1:0] TO_VAL = INT_W'(TIMEOUT);
  localparam logic [INT_W-1:0] TO_M1  = INT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_a_q;
  logic             r_a_q2;
  logic             r_b_q;
  logic [INT_W-1:0] r_timer;
  logic [INT_W-1:0] w_timer_next;
  logic             w_rise;
  logic             w_capture;
  logic [INT_W-1:0] w_capture_val;
  logic             w_soft_rst;

  assign w_rise     = r_a_q & ~r_a_q2;
  assign w_soft_rst = ~rst_n | clear;

  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A rise always wins over a timeout tick in the same cycle.
  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_capture     = 1'b0;
    w_capture_val = r_timer;
    case (r_state)
      ST_IDLE: begin
        w_timer_next = '0;
        if (w_rise) w_state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_capture    = 1'b1;
          w_timer_next = '0;
        end else if (tick) begin
          if (r_timer == TO_M1) begin
            w_state_next  = ST_STOPPED;
            w_capture     = 1'b1;
            w_capture_val = TO_VAL;
            w_timer_next  = '0;
          end else begin
            w_timer_next = r_timer + INT_W'(1);
          end
        end
      end
      ST_STOPPED: begin
        w_timer_next = '0;
        if (w_rise) w_state_next = ST_MEASURE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      r_a_q           <= 1'b0;
      r_a_q2          <= 1'b0;
      r_b_q           <= 1'b0;
      r_timer         <= '0;
      encoder_counter <= '0;
      interval_time   <= '0;
      dir             <= 1'b0;
      meas_valid      <= 1'b0;
      stopped         <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      r_a_q   <= enc_a;
      r_a_q2  <= r_a_q;
      r_b_q   <= enc_b;
      r_timer <= w_timer_next;
      stopped <= (w_state_next == ST_STOPPED);
      if (w_rise) begin
        dir <= ~r_b_q;
        if (r_b_q) encoder_counter <= encoder_counter - CNT_W'(1);
        else       encoder_counter <= encoder_counter + CNT_W'(1);
      end
      // A capture over an unconsumed value loses it, hence the sticky overrun.
      if (w_capture) begin
        interval_time <= w_capture_val;
        meas_valid    <= 1'b1;
        if (meas_valid && !meas_ready) overrun <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder_interval_ctrl.sv
// Testbench for encoder_interval_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the measurement rules.
module tb_encoder_interval_ctrl;

  localparam int CNT_W   = 9;
  localparam int INT_W   = 9;
  localparam int TIMEOUT = 511;
  localparam int MOD     = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enc_a = 1'b0;
  logic             enc_b = 1'b0;
  logic             tick = 1'b0;
  logic             clear = 1'b0;
  logic             meas_ready = 1'b0;
  logic [CNT_W-1:0] encoder_counter;
  logic [INT_W-1:0] interval_time;
  logic             dir;
  logic             meas_valid;
  logic             stopped;
  logic             overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: position as an integer modulo 2^CNT_W, elapsed ticks as a plain count.
  int m_pos, m_ticks, m_val;
  bit m_dir, m_valid, m_ovr, m_stopped, m_measuring;
  bit m_a1, m_a2, m_b1;

  encoder_interval_ctrl #(.CNT_W(CNT_W), .INT_W(INT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .tick(tick), .clear(clear),
    .encoder_counter(encoder_counter), .interval_time(interval_time), .dir(dir),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .stopped(stopped), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit rise, bq, cap;
    int val;
    if (!rst_n || clear) begin
      m_pos = 0; m_ticks = 0; m_val = 0;
      m_dir = 0; m_valid = 0; m_ovr = 0; m_stopped = 0; m_measuring = 0;
      m_a1 = 0; m_a2 = 0; m_b1 = 0;
      return;
    end
    rise = m_a1 && !m_a2;
    bq   = m_b1;
    m_a2 = m_a1; m_a1 = enc_a; m_b1 = enc_b;
    cap = 0; val = 0;
    if (rise) begin
      m_pos = bq ? (m_pos + MOD - 1) % MOD : (m_pos + 1) % MOD;
      m_dir = !bq;
      if (m_measuring) begin cap = 1; val = m_ticks; end
      m_measuring = 1; m_stopped = 0; m_ticks = 0;
    end else if (tick && m_measuring) begin
      if (m_ticks == TIMEOUT - 1) begin
        cap = 1; val = TIMEOUT; m_stopped = 1; m_measuring = 0; m_ticks = 0;
      end else begin
        m_ticks++;
      end
    end
    if (cap) begin
      if (m_valid && !meas_ready) m_ovr = 1;
      m_val = val; m_valid = 1;
    end else if (m_valid && meas_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    if (rst_n && !clear && meas_valid && meas_ready)
      $display("xfer: interval_time=%0d overrun=%0d", interval_time, overrun);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic a_pulse(input logic b);
    enc_b = b; enc_a = 1'b1; cycle();
    enc_a = 1'b0; cycle();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin tick = 1'b1; cycle(); end
    tick = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cycle(); cycle();
    n_checks++;
    if ({encoder_counter, interval_time, dir, meas_valid, stopped, overrun} !== '0) begin
      n_fail++; $display("FAIL reset_init: outputs=%h want 0", {encoder_counter, interval_time, dir, meas_valid, stopped, overrun});
    end
    rst_n = 1'b1; meas_ready = 1'b0;
    a_pulse(0); run_ticks(4); a_pulse(0);
    n_checks++;
    if (meas_valid !== 1'b1 || interval_time !== 9'd4) begin
      n_fail++; $display("FAIL reset_premeasure: valid=%0d interval=%0d want 1/4", meas_valid, interval_time);
    end
    run_ticks(2);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    n_checks++;
    if ({encoder_counter, interval_time, dir, meas_valid, stopped, overrun} !== '0) begin
      n_fail++; $display("FAIL reset_mid: outputs=%h want 0", {encoder_counter, interval_time, dir, meas_valid, stopped, overrun});
    end
    a_pulse(0);
    n_checks++;
    if (meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_first_edge: valid=%0d want 0", meas_valid);
    end
    run_ticks(3); a_pulse(0);
    n_checks++;
    if (meas_valid !== 1'b1 || interval_time !== 9'd3) begin
      n_fail++; $display("FAIL clear_premeasure: valid=%0d interval=%0d want 1/3", meas_valid, interval_time);
    end
    do_clear();
    n_checks++;
    if ({encoder_counter, interval_time, dir, meas_valid, stopped, overrun} !== '0) begin
      n_fail++; $display("FAIL clear_mid: outputs=%h want 0", {encoder_counter, interval_time, dir, meas_valid, stopped, overrun});
    end
    a_pulse(0);
    n_checks++;
    if (meas_valid !== 1'b0 || encoder_counter !== 9'd1) begin
      n_fail++; $display("FAIL clear_idle_first_edge: valid=%0d cnt=%0d want 0/1", meas_valid, encoder_counter);
    end
  endtask

  task automatic test_forward();
    int n_meas = 0;
    do_clear(); meas_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) run_ticks(10);
      a_pulse(0);
      if (meas_valid) n_meas++;
      n_checks++;
      if (i > 0 && interval_time !== 9'd10) begin
        n_fail++; $display("FAIL fwd_interval[%0d]: interval=%0d want 10", i, interval_time);
      end
    end
    n_checks++;
    if (n_meas != 4) begin
      n_fail++; $display("FAIL fwd_meas_count: got %0d want 4", n_meas);
    end
    n_checks++;
    if (encoder_counter !== 9'd5 || dir !== 1'b1) begin
      n_fail++; $display("FAIL fwd_count: cnt=%0d dir=%0d want 5/1", encoder_counter, dir);
    end
  endtask

  task automatic test_reverse_wrap();
    do_clear();
    a_pulse(1);
    n_checks++;
    if (encoder_counter !== 9'd511 || dir !== 1'b0) begin
      n_fail++; $display("FAIL rev_wrap: cnt=%0d dir=%0d want 511/0", encoder_counter, dir);
    end
    a_pulse(0); a_pulse(0);
    n_checks++;
    if (encoder_counter !== 9'd1 || dir !== 1'b1) begin
      n_fail++; $display("FAIL fwd_wrap: cnt=%0d dir=%0d want 1/1", encoder_counter, dir);
    end
  endtask

  task automatic test_timeout();
    do_clear(); meas_ready = 1'b0;
    a_pulse(0); run_ticks(TIMEOUT - 1);
    n_checks++;
    if (stopped !== 1'b0 || meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: stopped=%0d valid=%0d want 0/0", stopped, meas_valid);
    end
    run_ticks(1);
    n_checks++;
    if (stopped !== 1'b1 || meas_valid !== 1'b1 || interval_time !== 9'd511) begin
      n_fail++; $display("FAIL timeout: stopped=%0d valid=%0d interval=%0d want 1/1/511", stopped, meas_valid, interval_time);
    end
    a_pulse(0);
    n_checks++;
    if (stopped !== 1'b0 || meas_valid !== 1'b1 || interval_time !== 9'd511 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL timeout_resume: stopped=%0d valid=%0d interval=%0d ovr=%0d want 0/1/511/0", stopped, meas_valid, interval_time, overrun);
    end
  endtask

  task automatic test_backpressure();
    do_clear(); meas_ready = 1'b0;
    a_pulse(0); run_ticks(7); a_pulse(0);
    n_checks++;
    if (interval_time !== 9'd7 || meas_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL bp_first: interval=%0d valid=%0d ovr=%0d want 7/1/0", interval_time, meas_valid, overrun);
    end
    run_ticks(12);
    n_checks++;
    if (interval_time !== 9'd7 || meas_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: interval=%0d valid=%0d want 7/1", interval_time, meas_valid);
    end
    a_pulse(0);
    n_checks++;
    if (interval_time !== 9'd12 || meas_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL bp_overrun: interval=%0d valid=%0d ovr=%0d want 12/1/1", interval_time, meas_valid, overrun);
    end
    meas_ready = 1'b1; cycle(); meas_ready = 1'b0;
    n_checks++;
    if (meas_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain: valid=%0d ovr=%0d want 0/1", meas_valid, overrun);
    end
  endtask

  task automatic test_simultaneity();
    do_clear(); meas_ready = 1'b0;
    a_pulse(0); run_ticks(TIMEOUT - 1);
    enc_b = 1'b0; enc_a = 1'b1; cycle();
    enc_a = 1'b0; tick = 1'b1; cycle(); tick = 1'b0;
    n_checks++;
    if (interval_time !== 9'(TIMEOUT - 1) || stopped !== 1'b0 || meas_valid !== 1'b1) begin
      n_fail++; $display("FAIL sim_rise_tick: interval=%0d stopped=%0d valid=%0d want %0d/0/1", interval_time, stopped, meas_valid, TIMEOUT - 1);
    end
    run_ticks(3);
    enc_a = 1'b1; cycle();
    enc_a = 1'b0; meas_ready = 1'b1; cycle(); meas_ready = 1'b0;
    n_checks++;
    if (interval_time !== 9'd3 || meas_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL sim_rise_ready: interval=%0d valid=%0d ovr=%0d want 3/1/0", interval_time, meas_valid, overrun);
    end
  endtask

  task automatic test_random();
    int a_div = 4;
    int tick_pct = 50;
    int rdy_pct = 50;
    do_clear();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: begin a_div = 3;    tick_pct = 50;  end
          1: begin a_div = 20;   tick_pct = 80;  end
          2: begin a_div = 400;  tick_pct = 100; end
          default: begin a_div = 1500; tick_pct = 100; end
        endcase
        rdy_pct = ($urandom_range(0, 1) == 1) ? 80 : 10;
      end
      if ($urandom_range(1, a_div) == 1) enc_a = ~enc_a;
      enc_b      = 1'($urandom_range(0, 1));
      tick       = ($urandom_range(1, 100) <= tick_pct);
      meas_ready = ($urandom_range(1, 100) <= rdy_pct);
      clear      = ($urandom_range(0, 599) == 0);
      rst_n      = ($urandom_range(0, 999) != 0);
      cycle();
      n_checks++;
      if (encoder_counter !== CNT_W'(m_pos) || dir !== m_dir) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rnd_pos @%0d: cnt=%0d dir=%0d want %0d/%0d", c, encoder_counter, dir, m_pos, m_dir);
      end
      n_checks++;
      if (meas_valid !== m_valid || interval_time !== INT_W'(m_val)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rnd_meas @%0d: valid=%0d interval=%0d want %0d/%0d", c, meas_valid, interval_time, m_valid, m_val);
      end
      n_checks++;
      if (stopped !== m_stopped || overrun !== m_ovr) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rnd_flags @%0d: stopped=%0d ovr=%0d want %0d/%0d", c, stopped, overrun, m_stopped, m_ovr);
      end
    end
    clear = 1'b0; rst_n = 1'b1; tick = 1'b0; enc_a = 1'b0; meas_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_timeout();
    test_backpressure();
    test_simultaneity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
